scan_ctrl_38: RTL and testbench
===============================

Name: scan_ctrl_38

Overview:
- Digit-scan controller sitting directly upstream of the 3-8 decoder.
- Drives the decoder's 3-bit select and 3-bit enable so that one of 8 display digits is active at a time, with a blanking gap between digits to prevent ghosting.
- Presents the 4-bit nibble belonging to the active digit for the downstream segment encoder.
- Masked-off digits are skipped.

Parameters:
- DWELL, 4: clock cycles each digit stays enabled; legal range 1..65535. Silicon value is 50000.
- BLANK_CYC, 1: clock cycles with decoder disabled between digits; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level, sampled on clk; begins scanning from IDLE
- stop  input  1  level, sampled on clk; returns to IDLE from any state; priority over start
- digit_mask  input  8  bit i = 1 means digit i is scanned
- data  input  32  display value; digit i shows data[4i+3:4i]
- sel  output  3  to decoder data_in; current digit index
- en  output  3  to decoder en; 3'b100 = decoder active, 3'b000 = all outputs off
- nibble  output  4  data[4*sel+3:4*sel], combinational from registered sel and live data
- busy  output  1  1 in SCAN or BLANK

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, sel=0, en=3'b000, busy=0, internal 16-bit counter cnt=0.
- sel, en, busy are registered. en only ever takes the values 3'b100 or 3'b000.
- first(m): lowest index i with m[i]=1.
- next(s,m): first index after s with m=1, searching cyclically s+1..7, 0..s. It may return s itself if s is the only enabled digit.
- IDLE:
  - en=000, sel holds.
  - start=1, stop=0, digit_mask!=0 at an edge: at that edge state=SCAN, sel=first(digit_mask), en=100, cnt=0, busy=1.
  - start=1 with digit_mask==0: stay IDLE.
- SCAN:
  - en=100; cnt increments each cycle.
  - When cnt==DWELL-1: state=BLANK, en=000, cnt=0.
  - en is therefore high for exactly DWELL cycles.
- BLANK:
  - en=000, sel holds; cnt increments.
  - When cnt==BLANK_CYC-1 and digit_mask!=0: state=SCAN, sel=next(sel,digit_mask), en=100, cnt=0.
  - When cnt==BLANK_CYC-1 and digit_mask==0: state=IDLE, busy=0.
- Per-digit period is DWELL+BLANK_CYC cycles. Wrap-around goes 7→0.
- digit_mask is sampled only when choosing a digit (IDLE exit, BLANK end). Changes mid-dwell do not cut the current digit short.
- stop=1 at any edge: state=IDLE, en=000, busy=0, cnt=0, sel holds. Takes effect at the same edge as, and overrides, any simultaneous start or transition.
- start while busy: ignored.
- Reset asserted mid-scan: en drops to 000 immediately, without waiting for clk.
- After reset deassertion, the block idles until start.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, then release with start=0 → sel=0, en=000, busy=0, nibble=data[3:0] for 10 cycles.
- Full scan (DWELL=4, BLANK_CYC=1, mask=8'hFF, data=32'h76543210): pulse start → en=100 for 4 cycles and 000 for 1 cycle per digit; sel goes 0,1,…,7,0; nibble equals sel each SCAN window; period 5 cycles.
- Skip/wrap (mask=8'b1000_0101) → sel sequence 0,2,7,0,2; nibble=0,2,7 with data as above.
- Single digit (mask=8'h10) → sel stays 4; en repeats 100×4 then 000×1.
- Stop priority: assert start and stop in the same cycle from IDLE → stays IDLE. Assert stop during SCAN of digit 3 → next edge en=000, busy=0, sel=3.
- Empty mask and async reset:
  - mask set to 0 during SCAN → finishes dwell, blanks, enters IDLE, busy=0.
  - start with mask=0 → stays IDLE.
  - rst_n pulled low mid-cycle during SCAN → en=000 before the next clk edge.

Source files
------------

// File: rtl/scan_ctrl_38.sv
// Digit-scan controller feeding a 3-8 decoder: one masked-in digit enabled at a time, blank gap between digits.
// sel/en/busy are registered (one edge after the deciding inputs); nibble is combinational from sel_q and live data.
module scan_ctrl_38 #(
    parameter int unsigned DWELL     = 4,
    parameter int unsigned BLANK_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  digit_mask,
    input  logic [31:0] data,
    output logic [2:0]  sel,
    output logic [2:0]  en,
    output logic [3:0]  nibble,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);

    state_t      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  en_q, en_d;
    logic        busy_q, busy_d;
    logic [15:0] cnt_q, cnt_d;

    // Cyclic search s+1..7,0..s; next_idx(7, m) is therefore the lowest set bit.
    function automatic logic [2:0] next_idx(input logic [2:0] s, input logic [7:0] m);
        logic [2:0] r;
        logic [2:0] c;
        logic       found;
        r     = s;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            c = s + 3'(k);
            if (!found && m[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            en_q    <= 3'b000;
            busy_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (start && (digit_mask != 8'd0)) begin
                    state_d = SCAN;
                    sel_d   = next_idx(3'd7, digit_mask);
                end
            end
            SCAN: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = BLANK;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d = 16'd0;
                    if (digit_mask != 8'd0) begin
                        state_d = SCAN;
                        sel_d   = next_idx(sel_q, digit_mask);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
        // stop wins over every other transition but leaves sel where it was.
        if (stop) begin
            state_d = IDLE;
            sel_d   = sel_q;
            cnt_d   = 16'd0;
        end
    end

    always_comb begin
        en_d   = (state_d == SCAN) ? 3'b100 : 3'b000;
        busy_d = (state_d != IDLE);
    end

    assign sel    = sel_q;
    assign en     = en_q;
    assign busy   = busy_q;
    assign nibble = data[{sel_q, 2'b00} +: 4];

endmodule

// File: tb/tb_scan_ctrl_38.sv
// Bench for scan_ctrl_38: directed scenarios plus random traffic against a digit/period-position model.
module tb_scan_ctrl_38;

    localparam int DWELL     = 4;
    localparam int BLANK_CYC = 1;
    localparam int PERIOD    = DWELL + BLANK_CYC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  digit_mask = 8'hFF;
    logic [31:0] data = 32'h76543210;
    logic [2:0]  sel;
    logic [2:0]  en;
    logic [3:0]  nibble;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: whether a digit is being shown, which one, and how far into its period we are.
    int m_busy = 0;
    int m_sel  = 0;
    int m_t    = 0;

    scan_ctrl_38 #(.DWELL(DWELL), .BLANK_CYC(BLANK_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .digit_mask(digit_mask), .data(data),
        .sel(sel), .en(en), .nibble(nibble), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_next(input int s, input logic [7:0] m);
        for (int k = 1; k <= 8; k++) begin
            if (m[(s + k) % 8]) return (s + k) % 8;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_sel  = 0;
        m_t    = 0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (stop) begin
            m_busy = 0;
            m_t    = 0;
        end else if (m_busy == 0) begin
            if (start && digit_mask != 8'd0) begin
                m_busy = 1;
                m_sel  = pick_next(7, digit_mask);
                m_t    = 0;
            end
        end else begin
            m_t++;
            if (m_t == PERIOD) begin
                m_t = 0;
                if (digit_mask != 8'd0) m_sel = pick_next(m_sel, digit_mask);
                else m_busy = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [2:0] exp_en;
        logic [3:0] exp_nib;
        exp_en  = (m_busy != 0 && m_t < DWELL) ? 3'b100 : 3'b000;
        exp_nib = 4'((data >> (4 * m_sel)) & 32'hF);
        chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
        chk({tag, ".en"}, 32'(en), 32'(exp_en));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy != 0));
        chk({tag, ".nibble"}, 32'(nibble), 32'(exp_nib));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [2:0] seen[$];
        logic [2:0] prev_en;
        logic [2:0] skip_exp [5];
        skip_exp = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};

        // Reset and idle
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step("idle");

        // Full scan of all eight digits and a wrap back to 0
        start = 1'b1;
        step("full_start");
        start = 1'b0;
        for (int i = 0; i < 8 * PERIOD + 2; i++) step("full");
        chk("full_wrap_sel", 32'(sel), 32'd0);
        stop = 1'b1;
        step("full_stop");
        stop = 1'b0;

        // Skip and wrap with a sparse mask
        digit_mask = 8'b1000_0101;
        start = 1'b1;
        step("skip_start");
        start = 1'b0;
        prev_en = en;
        seen.push_back(sel);
        for (int i = 0; i < 4 * PERIOD + 1; i++) begin
            step("skip");
            if (en === 3'b100 && prev_en !== 3'b100) seen.push_back(sel);
            prev_en = en;
        end
        chk("skip_count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < seen.size()) chk($sformatf("skip_seq%0d", i), 32'(seen[i]), 32'(skip_exp[i]));
            else chk($sformatf("skip_seq%0d", i), 32'hFFFF_FFFF, 32'(skip_exp[i]));
        end
        stop = 1'b1;
        step("skip_stop");
        stop = 1'b0;

        // Single enabled digit keeps re-selecting itself
        digit_mask = 8'h10;
        start = 1'b1;
        step("single_start");
        start = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) step("single");
        chk("single_sel", 32'(sel), 32'd4);

        // Stop during SCAN of digit 3
        digit_mask = 8'hFF;
        stop = 1'b1;
        step("single_stop");
        start = 1'b1;
        step("start_and_stop");
        chk("start_and_stop_busy", 32'(busy), 32'd0);
        stop = 1'b0;
        step("full2_start");
        start = 1'b0;
        for (int i = 0; i < 3 * PERIOD + 1; i++) step("to_digit3");
        chk("digit3_en", 32'(en), 32'b100);
        stop = 1'b1;
        step("stop_scan");
        stop = 1'b0;
        chk("stop_scan_en", 32'(en), 32'b000);
        chk("stop_scan_busy", 32'(busy), 32'd0);
        chk("stop_scan_sel", 32'(sel), 32'd3);

        // Mask cleared mid-dwell: finish, blank, drop to idle
        start = 1'b1;
        step("empty_start");
        start = 1'b0;
        step("empty_dwell");
        digit_mask = 8'h00;
        for (int i = 0; i < PERIOD + 2; i++) step("empty_drain");
        chk("empty_busy", 32'(busy), 32'd0);
        start = 1'b1;
        step("start_mask0");
        start = 1'b0;
        chk("start_mask0_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a SCAN window
        digit_mask = 8'h22;
        start = 1'b1;
        step("arst_start");
        start = 1'b0;
        step("arst_dwell");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(en), 32'b000);
        chk("arst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_all("arst_after");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) digit_mask = 8'($urandom);
            if ($urandom_range(0, 29) == 0) digit_mask = 8'h00;
            if ($urandom_range(0, 9) == 0) data = $urandom;
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            step("rand");
        end
        start = 1'b0;
        stop  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
